gpio_mmio: RTL and testbench

GPIO_MMIO -- requirements
Module: gpio_mmio

---
 rtl/gpio_mmio.sv | 161 ++++++++++++++++
 tb/tb_gpio_mmio.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: synchronized inputs with rising-edge interrupts, output register, 7-segment registers.
// Define GPIO_DEBOUNCE_EN to add a per-bit debounce counter between the synchronizer and IN.
module gpio_mmio #(
  parameter int          N_IN       = 4,
  parameter int          N_OUT      = 4,
  parameter int          N_SEG      = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          DEB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [31:0]        a,
  input  logic [31:0]        wd,
  input  logic [2:0]         funct3,
  output logic [31:0]        rd,
  input  logic [N_IN-1:0]    pins_in,
  output logic [N_OUT-1:0]   pins_out,
  output logic [7*N_SEG-1:0] seg,
  output logic               irq
);

  localparam logic [5:0] OFF_IN    = 6'h00;
  localparam logic [5:0] OFF_OUT   = 6'h04;
  localparam logic [5:0] OFF_SET   = 6'h08;
  localparam logic [5:0] OFF_CLR   = 6'h0C;
  localparam logic [5:0] OFF_TGL   = 6'h10;
  localparam logic [5:0] OFF_EDGE  = 6'h14;
  localparam logic [5:0] OFF_IRQEN = 6'h18;

  logic              w_inWin;
  logic              w_wr;
  logic [5:0]        w_off;
  logic [N_IN-1:0]   r_sync1;
  logic [N_IN-1:0]   r_sync2;
  logic [N_IN-1:0]   r_stable;
  logic [N_IN-1:0]   r_inPrev;
  logic [N_IN-1:0]   r_edge;
  logic [N_IN-1:0]   r_irqEn;
  logic [N_IN-1:0]   w_rise;
  logic [N_IN-1:0]   w_edgeClr;
  logic [N_OUT-1:0]  r_out;
  logic [6:0]        r_seg [N_SEG];
  logic              r_irq;
  logic              w_unused;

  assign w_inWin  = (a[31:6] == BASE_ADDR[31:6]);
  assign w_off    = a[5:0];
  assign w_wr     = we && (funct3 == 3'b010) && w_inWin;
  assign w_unused = ^wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pins_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int              CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] r_cnt [N_IN];

  // A bit only moves to the new level after it has differed for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < N_IN; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stable <= '0;
    else       r_stable <= r_sync2;
  end
`endif

  // A new edge wins over a coincident write-1-to-clear.
  assign w_rise    = r_stable & ~r_inPrev;
  assign w_edgeClr = (w_wr && (w_off == OFF_EDGE)) ? wd[N_IN-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inPrev <= '0;
      r_edge   <= '0;
      r_irqEn  <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_inPrev <= r_stable;
      r_edge   <= (r_edge & ~w_edgeClr) | w_rise;
      if (w_wr && (w_off == OFF_IRQEN)) r_irqEn <= wd[N_IN-1:0];
      r_irq    <= |(r_edge & r_irqEn);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_wr) begin
      case (w_off)
        OFF_OUT: r_out <= wd[N_OUT-1:0];
        OFF_SET: r_out <= r_out | wd[N_OUT-1:0];
        OFF_CLR: r_out <= r_out & ~wd[N_OUT-1:0];
        OFF_TGL: r_out <= r_out ^ wd[N_OUT-1:0];
        default: r_out <= r_out;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_SEG; k++) r_seg[k] <= '0;
    end else begin
      for (int k = 0; k < N_SEG; k++) begin
        if (w_wr && (w_off == 6'(32 + 4 * k))) r_seg[k] <= wd[6:0];
      end
    end
  end

  always_comb begin
    seg = '0;
    for (int k = 0; k < N_SEG; k++) seg[7*k +: 7] = r_seg[k];
  end

  assign pins_out = r_out;
  assign irq      = r_irq;

  // Write-only, unmapped and out-of-window addresses all read as zero.
  always_comb begin
    rd = '0;
    if (w_inWin) begin
      case (w_off)
        OFF_IN:    rd[N_IN-1:0]  = r_stable;
        OFF_OUT:   rd[N_OUT-1:0] = r_out;
        OFF_EDGE:  rd[N_IN-1:0]  = r_edge;
        OFF_IRQEN: rd[N_IN-1:0]  = r_irqEn;
        default: begin
          for (int k = 0; k < N_SEG; k++) begin
            if (w_off == 6'(32 + 4 * k)) rd[6:0] = r_seg[k];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed bench for gpio_mmio; expected values go into a scoreboard queue as stimulus is applied.
// Extra debounce-filter checks are compiled when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_mmio;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_IN   = BASE + 32'h00;
  localparam logic [31:0] A_OUT  = BASE + 32'h04;
  localparam logic [31:0] A_SET  = BASE + 32'h08;
  localparam logic [31:0] A_CLR  = BASE + 32'h0C;
  localparam logic [31:0] A_TGL  = BASE + 32'h10;
  localparam logic [31:0] A_EDGE = BASE + 32'h14;
  localparam logic [31:0] A_IEN  = BASE + 32'h18;
  localparam logic [31:0] A_SEG0 = BASE + 32'h20;
  localparam logic [31:0] A_SEG1 = BASE + 32'h24;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [2:0]  funct3;
  logic [31:0] rd;
  logic [3:0]  pinsIn;
  logic [3:0]  pinsOut;
  logic [13:0] seg;
  logic        irq;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expect_t;

  expect_t sbQ[$];
  int      nChecks = 0;
  int      nPass   = 0;

  gpio_mmio #(
    .N_IN(4), .N_OUT(4), .N_SEG(2), .BASE_ADDR(BASE), .DEB_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .funct3(funct3), .rd(rd),
    .pins_in(pinsIn), .pins_out(pinsOut), .seg(seg), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpect(input string tag, input logic [31:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    expect_t e;
    nChecks++;
    if (sbQ.size() == 0) begin
      $error("[TB] FAIL scoreboard_empty: observed 0x%08h expected none", observed);
      return;
    end
    e = sbQ.pop_front();
    assert (observed === e.value) nPass++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", e.tag, observed, e.value);
  endtask

  task automatic checkSig(input string tag, input logic [31:0] observed, input logic [31:0] value);
    pushExpect(tag, value);
    checkOutput(observed);
  endtask

  task automatic checkRead(input string tag, input logic [31:0] addr, input logic [31:0] value);
    pushExpect(tag, value);
    a = addr;
    #1;
    checkOutput(rd);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    we     = 1'b1;
    a      = addr;
    wd     = data;
    funct3 = f3;
    tick();
    we     = 1'b0;
    wd     = '0;
    funct3 = 3'b010;
  endtask

  task automatic waitIn(input string tag, input logic [31:0] value, input logic [31:0] mask);
    for (int i = 0; i < 100; i++) begin
      a = A_IN;
      #1;
      if ((rd & mask) === value) break;
      tick();
    end
    pushExpect(tag, value);
    a = A_IN;
    #1;
    checkOutput(rd & mask);
  endtask

  initial begin
    reset  = 1'b1;
    we     = 1'b0;
    a      = A_IN;
    wd     = '0;
    funct3 = 3'b010;
    pinsIn = 4'hF;
    #1;
    checkSig("rst_imm_pins_out", 32'(pinsOut), 32'h0);
    checkSig("rst_imm_irq", 32'(irq), 32'h0);
    repeat (3) tick();
    checkSig("rst_pins_out", 32'(pinsOut), 32'h0);
    checkSig("rst_seg", 32'(seg), 32'h0);
    checkSig("rst_irq", 32'(irq), 32'h0);
    checkRead("rst_in", A_IN, 32'h0);
    checkRead("rst_edge", A_EDGE, 32'h0);

    // First write lands on the first edge after reset release.
    reset = 1'b0;
    applyStimulus(A_OUT, 32'h5, 3'b010);
    checkSig("out_sw5", 32'(pinsOut), 32'h5);
`ifndef GPIO_DEBOUNCE_EN
    checkRead("in_lat1", A_IN, 32'h0);
`endif
    applyStimulus(A_SET, 32'h2, 3'b010);
    checkSig("out_set2", 32'(pinsOut), 32'h7);
`ifndef GPIO_DEBOUNCE_EN
    checkRead("in_lat2", A_IN, 32'h0);
`endif
    applyStimulus(A_CLR, 32'h4, 3'b010);
    checkSig("out_clr4", 32'(pinsOut), 32'h3);
`ifndef GPIO_DEBOUNCE_EN
    checkRead("in_lat3", A_IN, 32'hF);
`endif
    applyStimulus(A_TGL, 32'h9, 3'b010);
    checkSig("out_tgl9", 32'(pinsOut), 32'hA);
`ifndef GPIO_DEBOUNCE_EN
    checkRead("edge_after_in", A_EDGE, 32'hF);
`endif
    checkRead("set_reads_0", A_SET, 32'h0);
    checkRead("out_readback", A_OUT, 32'hA);

    waitIn("in_all_high", 32'hF, 32'hF);
    tick();
    checkRead("edge_all", A_EDGE, 32'hF);
    applyStimulus(A_EDGE, 32'h5, 3'b010);
    checkRead("edge_w1c_part", A_EDGE, 32'hA);
    applyStimulus(A_EDGE, 32'hFFFF_FFFF, 3'b010);
    checkRead("edge_w1c_all", A_EDGE, 32'h0);
    pinsIn = 4'h0;
    waitIn("in_all_low", 32'h0, 32'hF);
    tick();
    checkRead("edge_no_fall", A_EDGE, 32'h0);

    applyStimulus(A_OUT, 32'hF, 3'b000);
    checkSig("sb_ignored", 32'(pinsOut), 32'hA);
    applyStimulus(A_SEG1, 32'h7F, 3'b010);
    checkSig("seg1_7f", 32'(seg), 32'h3F80);
    checkRead("seg1_read", A_SEG1, 32'h7F);
    applyStimulus(A_SEG0, 32'hFFFF_FF92, 3'b010);
    checkSig("seg0_low7", 32'(seg), 32'h3F92);
    checkRead("seg0_read", A_SEG0, 32'h12);
    checkRead("unmapped_3c", BASE + 32'h3C, 32'h0);
    checkRead("out_of_window", BASE + 32'h40, 32'h0);
    applyStimulus(32'h0000_2004, 32'h0, 3'b010);
    checkSig("oow_write", 32'(pinsOut), 32'hA);
    applyStimulus(A_OUT, 32'hFFFF_FFF0, 3'b010);
    checkSig("out_upper_ignored", 32'(pinsOut), 32'h0);

    applyStimulus(A_IEN, 32'h1, 3'b010);
    checkRead("irqen_read", A_IEN, 32'h1);
    checkSig("irq_idle", 32'(irq), 32'h0);
    pinsIn = 4'h1;
    waitIn("in0_rise_a", 32'h1, 32'hF);
    tick();
    checkRead("edge0_set", A_EDGE, 32'h1);
    checkSig("irq_not_yet", 32'(irq), 32'h0);
    tick();
    checkSig("irq_set", 32'(irq), 32'h1);
    applyStimulus(A_EDGE, 32'h1, 3'b010);
    checkRead("edge0_clr", A_EDGE, 32'h0);
    checkSig("irq_lag", 32'(irq), 32'h1);
    tick();
    checkSig("irq_clr", 32'(irq), 32'h0);

    pinsIn = 4'h0;
    waitIn("in0_fall_b", 32'h0, 32'hF);
    pinsIn = 4'h1;
    waitIn("in0_rise_b", 32'h1, 32'hF);
    tick();
    tick();
    checkSig("irq_set_b", 32'(irq), 32'h1);
    pinsIn = 4'h0;
    waitIn("in0_fall_c", 32'h0, 32'hF);
    pinsIn = 4'h1;
    waitIn("in0_rise_c", 32'h1, 32'hF);
    applyStimulus(A_EDGE, 32'h1, 3'b010);
    checkRead("edge_clr_vs_new", A_EDGE, 32'h1);
    checkSig("irq_hold_a", 32'(irq), 32'h1);
    tick();
    checkSig("irq_hold_b", 32'(irq), 32'h1);
    applyStimulus(A_IEN, 32'h0, 3'b010);
    checkSig("irq_en_lag", 32'(irq), 32'h1);
    tick();
    checkSig("irq_en_off", 32'(irq), 32'h0);

    // Asynchronous reset in the middle of activity, with no clock edge needed.
    applyStimulus(A_OUT, 32'h6, 3'b010);
    applyStimulus(A_SEG0, 32'h55, 3'b010);
    applyStimulus(A_IEN, 32'h1, 3'b010);
    tick();
    checkSig("irq_pre_reset", 32'(irq), 32'h1);
    reset = 1'b1;
    #1;
    checkSig("arst_pins_out", 32'(pinsOut), 32'h0);
    checkSig("arst_seg", 32'(seg), 32'h0);
    checkSig("arst_irq", 32'(irq), 32'h0);
    checkRead("arst_edge", A_EDGE, 32'h0);
    checkRead("arst_irqen", A_IEN, 32'h0);
    pinsIn = 4'h0;
    tick();
    tick();
    reset = 1'b0;
    repeat (6) tick();
    checkRead("held0_no_edge", A_EDGE, 32'h0);
    checkRead("held0_in", A_IN, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    pinsIn = 4'h1;
    repeat (10) tick();
    pinsIn = 4'h0;
    repeat (30) tick();
    checkRead("deb_pulse_in", A_IN, 32'h0);
    checkRead("deb_pulse_edge", A_EDGE, 32'h0);
    pinsIn = 4'h1;
    repeat (25) tick();
    checkRead("deb_hold_in", A_IN, 32'h1);
    checkRead("deb_hold_edge", A_EDGE, 32'h1);
    applyStimulus(A_EDGE, 32'h1, 3'b010);
    repeat (30) tick();
    checkRead("deb_edge_once", A_EDGE, 32'h0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
